// File: rtl/normalize_sub_pipe_pkg.sv
// Shared defaults for the layer-norm mean-subtract stage.
package normalize_sub_pipe_pkg;

  localparam int unsigned DefN   = 64;  // lanes
  localparam int unsigned DefW   = 16;  // lane width, two's complement
  localparam int unsigned DefLat = 2;   // pipeline depth
  localparam int unsigned DefShw = 4;   // shift field width

endpackage

// File: rtl/norm_sub_lane.sv
// One lane of the mean-subtract datapath: subtract/shift half and clip half are
// separate so the top can place a register between them.
module norm_sub_lane
  import normalize_sub_pipe_pkg::*;
#(
  parameter int unsigned W   = DefW,
  parameter int unsigned SHW = DefShw
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   mu,
  input  logic [SHW-1:0] shift,
  output logic [W:0]     s_wide,
  input  logic [W:0]     s_in,
  input  logic           sat_en,
  output logic [W-1:0]   res,
  output logic           lane_sat
);

  logic signed [W:0] d;
  logic              ovf;

  // W+1-bit difference cannot overflow; arithmetic shift fills with the sign.
  always_comb begin
    d      = $signed({x[W-1], x}) - $signed({mu[W-1], mu});
    s_wide = d >>> shift;
  end

  // Out of W-bit range exactly when the top two bits disagree.
  always_comb begin
    ovf      = s_in[W] ^ s_in[W-1];
    res      = s_in[W-1:0];
    lane_sat = 1'b0;
    if (sat_en && ovf) begin
      res      = s_in[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      lane_sat = 1'b1;
    end
  end

endmodule

// File: rtl/normalize_sub_pipe.sv
// N-lane vector mean-subtract stage: diff[i] = (x[i] - mu) >>> shift with optional
// saturation, LAT-deep pipeline with valid/ready backpressure.
module normalize_sub_pipe
  import normalize_sub_pipe_pkg::*;
#(
  parameter int unsigned N   = DefN,
  parameter int unsigned W   = DefW,
  parameter int unsigned LAT = DefLat,
  parameter int unsigned SHW = DefShw
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] x_in,
  input  logic [W-1:0]   mu,
  input  logic [SHW-1:0] shift,
  input  logic           sat_en,
  output logic [N*W-1:0] diff_out,
  output logic           sat_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [31:0]    beat_cnt
);

  // Stages holding final-form results; with LAT>=2 stage 0 holds the unclipped value.
  localparam int unsigned FinDepth = (LAT > 1) ? LAT - 1 : 1;

  logic [LAT-1:0]       v_q;
  logic                 adv;
  logic [N*(W+1)-1:0]   s_wide;
  logic [N*(W+1)-1:0]   clip_in;
  logic                 clip_sat_en;
  logic [N*W-1:0]       res_c;
  logic [N-1:0]         lane_sat;
  logic [N*W-1:0]       dat_q [FinDepth];
  logic [FinDepth-1:0]  sat_q;
  logic [31:0]          cnt_q;

  // Whole pipe moves together whenever the output slot is empty or being drained.
  always_comb begin
    adv      = ~v_q[LAT-1] | out_ready;
    in_ready = adv;
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    norm_sub_lane #(
      .W   (W),
      .SHW (SHW)
    ) u_lane (
      .x        (x_in[i*W +: W]),
      .mu       (mu),
      .shift    (shift),
      .s_wide   (s_wide[i*(W+1) +: (W+1)]),
      .s_in     (clip_in[i*(W+1) +: (W+1)]),
      .sat_en   (clip_sat_en),
      .res      (res_c[i*W +: W]),
      .lane_sat (lane_sat[i])
    );
  end

  if (LAT > 1) begin : g_split
    logic [N*(W+1)-1:0] s0_q;
    logic               se0_q;

    // Stage 0: register subtract/shift result and the beat's saturation mode.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s0_q  <= '0;
        se0_q <= 1'b0;
      end else if (adv) begin
        s0_q  <= s_wide;
        se0_q <= sat_en;
      end
    end

    assign clip_in     = s0_q;
    assign clip_sat_en = se0_q;
  end else begin : g_flat
    assign clip_in     = s_wide;
    assign clip_sat_en = sat_en;
  end

  // Clipped results and the beat-wide saturation flag, then pure delay stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < FinDepth; k++) dat_q[k] <= '0;
      sat_q <= '0;
    end else if (adv) begin
      dat_q[0] <= res_c;
      sat_q[0] <= |lane_sat;
      for (int unsigned k = 1; k < FinDepth; k++) begin
        dat_q[k] <= dat_q[k-1];
        sat_q[k] <= sat_q[k-1];
      end
    end
  end

  // Valid chain; bubbles shift along with data rather than being collapsed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
    end else if (adv) begin
      v_q[0] <= in_valid;
      for (int unsigned k = 1; k < LAT; k++) v_q[k] <= v_q[k-1];
    end
  end

  // Delivered-beat counter, wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (v_q[LAT-1] && out_ready) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign out_valid = v_q[LAT-1];
  assign diff_out  = dat_q[FinDepth-1];
  assign sat_out   = sat_q[FinDepth-1];
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_normalize_sub_pipe.sv
// Bench for normalize_sub_pipe: fixed vectors, backpressure, stall, reset and a
// random soak scored against an arithmetic reference model.
module tb_normalize_sub_pipe;

  localparam int unsigned Lanes = 4;
  localparam int unsigned Wd    = 16;
  localparam int unsigned Lat   = 2;
  localparam int unsigned Shw   = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] x_in;
  logic [15:0] mu;
  logic [3:0]  shift;
  logic        sat_en;
  logic [63:0] diff_out;
  logic        sat_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] beat_cnt;

  normalize_sub_pipe #(
    .N   (Lanes),
    .W   (Wd),
    .LAT (Lat),
    .SHW (Shw)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .mu        (mu),
    .shift     (shift),
    .sat_en    (sat_en),
    .diff_out  (diff_out),
    .sat_out   (sat_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .beat_cnt  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] x;
    logic [15:0] mu;
    logic [3:0]  sh;
    logic        se;
    logic [63:0] ed;
    logic        es;
  } vec_t;

  int          total;
  int          bad;
  int          exp_cnt;
  logic [64:0] exp_q[$];
  bit          acc;
  bit          dlv;
  bit          stall_prev;
  logic [64:0] stall_val;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] lanes4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // {sat, value} for one lane: floor division by 2^sh, then clip or wrap.
  function automatic logic [16:0] ref_lane(input int x, input int m, input int sh, input bit se);
    int d, p, q;
    d = x - m;
    p = 1 << sh;
    if (d >= 0) q = d / p;
    else        q = -((-d + p - 1) / p);
    if (se && q > 32767)  return {1'b1, 16'h7fff};
    if (se && q < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(q)};
  endfunction

  function automatic logic [64:0] ref_beat(input logic [63:0] xv, input logic [15:0] m,
                                           input logic [3:0] sh, input logic se);
    logic [63:0] dv;
    logic        s;
    logic [16:0] r;
    int          xi;
    int          mi;
    s  = 1'b0;
    dv = '0;
    mi = int'($signed(m));
    for (int i = 0; i < 4; i++) begin
      xi = int'($signed(xv[16*i +: 16]));
      r  = ref_lane(xi, mi, int'(sh), se);
      dv[16*i +: 16] = r[15:0];
      s  = s | r[16];
    end
    return {s, dv};
  endfunction

  // One clock: score handshakes due at the next edge, then advance to edge+1.
  task automatic tick();
    logic [64:0] e;
    #1;
    acc = 1'b0;
    dlv = 1'b0;
    if (stall_prev) begin
      chk("stall_valid_held", 65'(out_valid), 65'(1));
      chk("stall_data_held", {sat_out, diff_out}, stall_val);
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_beat(x_in, mu, shift, sat_en));
      acc = 1'b1;
    end
    if (out_valid && out_ready) begin
      dlv = 1'b1;
      if (exp_q.size() == 0) begin
        chk("sb_extra_beat", 65'(out_valid), 65'(0));
      end else begin
        e = exp_q.pop_front();
        chk("sb_beat", {sat_out, diff_out}, e);
        exp_cnt++;
      end
    end
    stall_prev = out_valid && !out_ready;
    stall_val  = {sat_out, diff_out};
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    x_in   = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) x_in[15:0] = ($urandom_range(0, 1) == 1) ? 16'h7fff : 16'h8000;
    mu     = 16'($urandom);
    if ($urandom_range(0, 3) == 0) mu = ($urandom_range(0, 1) == 1) ? 16'h7fff : 16'h8000;
    shift  = 4'($urandom);
    sat_en = 1'($urandom);
  endtask

  task automatic drain(input string name);
    int g;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      tick();
      g++;
    end
    chk(name, 65'(exp_q.size()), 65'(0));
  endtask

  vec_t        tv[8];
  int          lat;
  int          n_acc;
  int          guard;
  int          base;
  logic [3:0]  pat;

  initial begin
    total = 0; bad = 0; exp_cnt = 0; stall_prev = 1'b0; stall_val = '0;
    acc = 1'b0; dlv = 1'b0;
    rst = 1'b1; in_valid = 1'b0; x_in = '0; mu = '0; shift = '0; sat_en = 1'b0;
    out_ready = 1'b0;

    tv[0] = '{x: lanes4(100, 0, -5, 32767), mu: 16'd10, sh: 4'd0, se: 1'b1,
              ed: lanes4(90, -10, -15, 32757), es: 1'b0};
    tv[1] = '{x: lanes4(32767, 0, 1, -32768), mu: 16'hffff, sh: 4'd0, se: 1'b1,
              ed: lanes4(32767, 1, 2, -32767), es: 1'b1};
    tv[2] = '{x: lanes4(32767, 0, 1, -32768), mu: 16'hffff, sh: 4'd0, se: 1'b0,
              ed: lanes4(-32768, 1, 2, -32767), es: 1'b0};
    tv[3] = '{x: lanes4(-100, -100, 7, -32768), mu: 16'd0, sh: 4'd3, se: 1'b1,
              ed: lanes4(-13, -13, 0, -4096), es: 1'b0};
    tv[4] = '{x: lanes4(-100, 7, 32767, -32768), mu: 16'd0, sh: 4'd15, se: 1'b1,
              ed: lanes4(-1, 0, 0, -1), es: 1'b0};
    tv[5] = '{x: lanes4(-32768, 0, -1, 100), mu: 16'h7fff, sh: 4'd0, se: 1'b1,
              ed: lanes4(-32768, -32767, -32768, -32667), es: 1'b1};
    tv[6] = '{x: lanes4(-32768, 0, -1, 100), mu: 16'h7fff, sh: 4'd0, se: 1'b0,
              ed: lanes4(1, -32767, -32768, -32667), es: 1'b0};
    tv[7] = '{x: lanes4(32767, -32768, 0, 0), mu: 16'h8000, sh: 4'd1, se: 1'b1,
              ed: lanes4(32767, 0, 16384, 16384), es: 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 65'(out_valid), 65'(0));
    chk("rst_beat_cnt", 65'(beat_cnt), 65'(0));
    chk("rst_diff_out", 65'(diff_out), 65'(0));
    chk("rst_sat_out", 65'(sat_out), 65'(0));
    rst = 1'b0;

    // Fixed vectors, one beat at a time, latency and count checked
    for (int i = 0; i < 8; i++) begin
      x_in = tv[i].x; mu = tv[i].mu; shift = tv[i].sh; sat_en = tv[i].se;
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      chk($sformatf("vec%0d_accept", i), 65'(acc), 65'(1));
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        tick();
        lat++;
      end
      chk($sformatf("vec%0d_latency", i), 65'(lat), 65'(Lat));
      chk($sformatf("vec%0d_diff", i), 65'(diff_out), 65'(tv[i].ed));
      chk($sformatf("vec%0d_sat", i), 65'(sat_out), 65'(tv[i].es));
      tick();
      chk($sformatf("vec%0d_beat_cnt", i), 65'(beat_cnt), 65'(i + 1));
    end

    // Backpressure: 8 beats with out_ready pattern 1,0,0,1
    pat = 4'b1001;
    base = int'(beat_cnt);
    n_acc = 0; guard = 0;
    rand_beat();
    in_valid = 1'b1;
    while (n_acc < 8 && guard < 100) begin
      out_ready = pat[guard % 4];
      tick();
      if (acc) begin
        n_acc++;
        rand_beat();
      end
      guard++;
    end
    in_valid = 1'b0;
    while (exp_q.size() != 0 && guard < 200) begin
      out_ready = pat[guard % 4];
      tick();
      guard++;
    end
    chk("bp_accepted", 65'(n_acc), 65'(8));
    chk("bp_drained", 65'(exp_q.size()), 65'(0));
    chk("bp_beat_cnt", 65'(beat_cnt), 65'(base + 8));

    // Full stall: fill LAT beats with out_ready low, then release
    out_ready = 1'b0;
    rand_beat();
    in_valid = 1'b1;
    n_acc = 0; guard = 0;
    while (in_ready && guard < 10) begin
      tick();
      if (acc) begin
        n_acc++;
        rand_beat();
      end
      guard++;
    end
    chk("stall_inflight", 65'(n_acc), 65'(Lat));
    chk("stall_in_ready", 65'(in_ready), 65'(0));
    repeat (2) begin
      tick();
      chk("stall_no_accept", 65'(acc), 65'(0));
    end
    out_ready = 1'b1;
    repeat (6) begin
      tick();
      chk("resume_deliver", 65'(dlv), 65'(1));
      chk("resume_accept", 65'(acc), 65'(1));
      if (acc) rand_beat();
    end
    drain("stall_drained");

    // Random soak with random valid/ready, AXI-style source hold
    base = int'(beat_cnt);
    n_acc = 0;
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_beat();
      end
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      if (acc) n_acc++;
    end
    drain("soak_drained");
    chk("soak_beat_cnt", 65'(beat_cnt), 65'(base + n_acc));

    // Mid-stream reset with two beats in flight
    out_ready = 1'b0;
    in_valid = 1'b1;
    rand_beat();
    tick();
    rand_beat();
    tick();
    chk("pre_rst_out_valid", 65'(out_valid), 65'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 65'(out_valid), 65'(0));
    chk("mid_rst_beat_cnt", 65'(beat_cnt), 65'(0));
    exp_q.delete();
    stall_prev = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      tick();
      chk("post_rst_no_beat", 65'(out_valid), 65'(0));
    end
    chk("post_rst_beat_cnt", 65'(beat_cnt), 65'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
